// File: rtl/rx_phase_ctrl_if.sv
// Sample stream in, phase/lock status and hard decisions out, for one rail of
// the QPSK symbol-timing controller.
interface rx_phase_ctrl_if #(
    parameter int unsigned OS_RATE    = 4,
    parameter int unsigned FILT_NBITS = 8
);
    localparam int unsigned PhaseW = (OS_RATE > 1) ? $clog2(OS_RATE) : 1;

    logic                         enable;
    logic signed [FILT_NBITS-1:0] filt_in;
    logic [PhaseW-1:0]            phase_sel;
    logic                         locked;
    logic                         bit_out;
    logic                         bit_valid;

    // Sample source / decision consumer side.
    modport master (
        output enable, filt_in,
        input  phase_sel, locked, bit_out, bit_valid
    );

    // Timing-controller side.
    modport slave (
        input  enable, filt_in,
        output phase_sel, locked, bit_out, bit_valid
    );
endinterface

// File: rtl/rx_phase_ctrl.sv
// Symbol-timing controller: measures per-phase energy over a window of
// symbols, locks onto the strongest phase, then slices one bit per symbol.
module rx_phase_ctrl #(
    parameter int unsigned OS_RATE    = 4,
    parameter int unsigned FILT_NBITS = 8,
    parameter int unsigned WINDOW     = 511,
    parameter int unsigned ACC_NBITS  = 16
) (
    input logic          clk,
    input logic          rst,
    rx_phase_ctrl_if.slave rx
);
    localparam int unsigned PhaseW = (OS_RATE > 1) ? $clog2(OS_RATE) : 1;
    localparam int unsigned SymW   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned SumW   = ACC_NBITS + 1;
    localparam logic [ACC_NBITS-1:0] AccMax = '1;

    typedef enum logic [1:0] {StIdle, StAcq, StTrack} state_e;

    state_e                state_q;
    logic [PhaseW-1:0]     cnt_q;
    logic [SymW-1:0]       sym_q;
    logic [ACC_NBITS-1:0]  acc_q [OS_RATE];
    logic                  eval_q;

    logic [FILT_NBITS-1:0] raw;
    logic [FILT_NBITS-1:0] mag;
    logic [SumW-1:0]       sum;
    logic [ACC_NBITS-1:0]  acc_sat;
    logic [PhaseW-1:0]     best;
    logic                  cnt_last;
    logic                  sym_last;
    logic                  win_end;

    // Magnitude as unsigned so the most negative sample maps to 2^(FILT_NBITS-1).
    always_comb begin
        raw = rx.filt_in;
        mag = raw[FILT_NBITS-1] ? ({FILT_NBITS{1'b0}} - raw) : raw;
    end

    // Saturating accumulate for the current phase; the carry bit flags overflow.
    always_comb begin
        sum     = {1'b0, acc_q[cnt_q]} + SumW'(mag);
        acc_sat = sum[ACC_NBITS] ? AccMax : sum[ACC_NBITS-1:0];
    end

    // Strongest phase; strict compare keeps the lowest index on ties.
    always_comb begin
        best = '0;
        for (int unsigned p = 1; p < OS_RATE; p++) begin
            if (acc_q[p] > acc_q[best]) best = PhaseW'(p);
        end
    end

    // Window boundary detection.
    always_comb begin
        cnt_last = (cnt_q == PhaseW'(OS_RATE - 1));
        sym_last = (sym_q == SymW'(WINDOW - 1));
        win_end  = rx.enable & cnt_last & sym_last;
    end

    // Control FSM, counters, accumulators and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            sym_q        <= '0;
            eval_q       <= 1'b0;
            for (int unsigned p = 0; p < OS_RATE; p++) acc_q[p] <= '0;
            rx.phase_sel <= '0;
            rx.locked    <= 1'b0;
            rx.bit_out   <= 1'b0;
            rx.bit_valid <= 1'b0;
        end else begin
            rx.bit_valid <= 1'b0;
            eval_q       <= win_end;

            // Decisions use the phase_sel in force before any EVAL this cycle.
            if (state_q == StTrack && rx.enable && cnt_q == rx.phase_sel) begin
                rx.bit_out   <= ~rx.filt_in[FILT_NBITS-1];
                rx.bit_valid <= 1'b1;
            end

            if (rx.enable) begin
                cnt_q <= cnt_last ? '0 : cnt_q + PhaseW'(1);
                if (cnt_last) sym_q <= sym_last ? '0 : sym_q + SymW'(1);
            end

            // EVAL ignores enable; a concurrent sample seeds the fresh window.
            if (eval_q) begin
                rx.phase_sel <= best;
                rx.locked    <= 1'b1;
                state_q      <= StTrack;
                for (int unsigned p = 0; p < OS_RATE; p++) acc_q[p] <= '0;
                if (rx.enable) acc_q[cnt_q] <= ACC_NBITS'(mag);
            end else if (rx.enable) begin
                acc_q[cnt_q] <= acc_sat;
            end

            // The first enabled sample is already phase 0 of symbol 0.
            if (state_q == StIdle && rx.enable) state_q <= StAcq;
        end
    end
endmodule

// File: tb/tb_rx_phase_ctrl.sv
// Directed bench for rx_phase_ctrl with a sample-index based reference model.
module tb_rx_phase_ctrl;
    localparam int unsigned OS = 4;
    localparam int unsigned FB = 8;
    localparam int unsigned W  = 4;
    localparam int unsigned AB = 9;
    localparam int          AccMaxM = (1 << AB) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    rx_phase_ctrl_if #(.OS_RATE(OS), .FILT_NBITS(FB)) ifc ();

    rx_phase_ctrl #(
        .OS_RATE   (OS),
        .FILT_NBITS(FB),
        .WINDOW    (W),
        .ACC_NBITS (AB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx (ifc)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int vcnt    = 0;

    // Reference model state: samples counted since acquisition start.
    int m_k;
    int m_sum [OS];
    bit m_pend;
    int m_phase;
    bit m_locked;
    bit m_bv;
    bit m_bo;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit en, input int v);
        int ph;
        int mag;
        int best;
        int t;
        if (!r) begin
            m_k = 0;
            for (int p = 0; p < OS; p++) m_sum[p] = 0;
            m_pend = 0; m_phase = 0; m_locked = 0; m_bv = 0; m_bo = 0;
        end else begin
            ph   = m_k % OS;
            mag  = (v < 0) ? -v : v;
            m_bv = 0;
            if (en && m_locked && ph == m_phase) begin
                m_bo = (v >= 0);
                m_bv = 1;
            end
            if (m_pend) begin
                best = 0;
                for (int p = 1; p < OS; p++) if (m_sum[p] > m_sum[best]) best = p;
                m_phase  = best;
                m_locked = 1;
                for (int p = 0; p < OS; p++) m_sum[p] = 0;
                m_pend = 0;
            end
            if (en) begin
                t = m_sum[ph] + mag;
                m_sum[ph] = (t > AccMaxM) ? AccMaxM : t;
                if (m_k % (OS * W) == OS * W - 1) m_pend = 1;
                m_k++;
            end
        end
    endtask

    // One clock: drive, update model at the edge, compare at the falling edge.
    task automatic cycle(input bit en, input int v);
        ifc.enable  = en;
        ifc.filt_in = v[FB-1:0];
        @(posedge clk);
        model_step(rst, en, v);
        @(negedge clk);
        check("phase_sel", ifc.phase_sel, m_phase);
        check("locked", ifc.locked, m_locked);
        check("bit_valid", ifc.bit_valid, m_bv);
        check("bit_out", ifc.bit_out, m_bo);
        if (ifc.bit_valid) vcnt++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) cycle(1'b0, 0);
        rst = 1'b1;
    endtask

    function automatic int s2(input int i);
        return (i % 4 == 2) ? 100 : 0;
    endfunction

    function automatic int s4(input int i);
        return (i % 4 == 1) ? -128 : ((i % 4 == 3) ? 127 : 0);
    endfunction

    initial begin
        ifc.enable  = 1'b0;
        ifc.filt_in = '0;

        // Reset and idle.
        do_reset(3);
        vcnt = 0;
        repeat (20) cycle(1'b0, 0);
        check("s1_no_valid", vcnt, 0);
        check("s1_locked", ifc.locked, 0);
        check("s1_phase", ifc.phase_sel, 0);
        check("s1_bit_out", ifc.bit_out, 0);

        // Acquisition on phase 2.
        do_reset(1);
        vcnt = 0;
        for (int i = 0; i < 48; i++) begin
            cycle(1'b1, s2(i));
            if (i == 15) check("s2_prelock", ifc.locked, 0);
            if (i == 16) begin
                check("s2_lock", ifc.locked, 1);
                check("s2_phase", ifc.phase_sel, 2);
            end
            if (ifc.bit_valid) check("s2_bit", ifc.bit_out, 1);
        end
        cycle(1'b0, 0);
        check("s2_pulses", vcnt, 8);

        // Ties and sign.
        do_reset(1);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, -50);
            if (i == 16) begin
                check("s3_lock", ifc.locked, 1);
                check("s3_phase", ifc.phase_sel, 0);
            end
            if (ifc.bit_valid) check("s3_bit_neg", ifc.bit_out, 0);
        end
        vcnt = 0;
        for (int i = 40; i < 64; i++) begin
            cycle(1'b1, 0);
            if (ifc.bit_valid) check("s3_bit_zero", ifc.bit_out, 1);
        end
        check("s3_pulses", vcnt, 6);
        check("s3_phase_end", ifc.phase_sel, 0);

        // Saturation: phase 1 sums to 512 and must clamp at 511, still beating 508.
        do_reset(1);
        for (int i = 0; i < 24; i++) begin
            cycle(1'b1, s4(i));
            if (i == 16) begin
                check("s4_lock", ifc.locked, 1);
                check("s4_phase", ifc.phase_sel, 1);
            end
            if (ifc.bit_valid) check("s4_bit", ifc.bit_out, (s4(i) >= 0) ? 1 : 0);
        end

        // Enable gaps, including on the EVAL cycle.
        do_reset(1);
        vcnt = 0;
        for (int i = 0; i < 48; i++) begin
            if (i == 7) repeat (10) cycle(1'b0, 0);
            cycle(1'b1, s2(i));
            if (ifc.bit_valid) check("s5_bit", ifc.bit_out, 1);
            if (i == 15) begin
                check("s5_prelock", ifc.locked, 0);
                cycle(1'b0, 0);
                check("s5_lock_gap", ifc.locked, 1);
                check("s5_phase_gap", ifc.phase_sel, 2);
            end
        end
        cycle(1'b0, 0);
        check("s5_pulses", vcnt, 8);

        // Reset mid-TRACK with an EVAL pending.
        do_reset(1);
        for (int i = 0; i < 32; i++) cycle(1'b1, s2(i));
        rst = 1'b0;
        cycle(1'b1, 100);
        rst = 1'b1;
        check("s6_locked", ifc.locked, 0);
        check("s6_phase", ifc.phase_sel, 0);
        check("s6_valid", ifc.bit_valid, 0);
        check("s6_bit_out", ifc.bit_out, 0);
        cycle(1'b0, 0);
        check("s6_eval_dropped", ifc.locked, 0);
        for (int i = 0; i < 16; i++) cycle(1'b1, s2(i));
        check("s6_relock_wait", ifc.locked, 0);
        cycle(1'b1, s2(16));
        check("s6_relock", ifc.locked, 1);
        check("s6_rephase", ifc.phase_sel, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rx_phase_ctrl.md
# rx_phase_ctrl

Symbol-timing controller for the QPSK receive path. It sits directly after the RX matched filter and observes the oversampled filter output for one rail. Per decision window it measures the energy at each oversampling phase, selects the strongest phase, then issues one hard bit decision per symbol at that phase with a valid strobe.

## Interface
Parameters:
- OS_RATE, 4: samples per symbol; number of phases tracked.
- FILT_NBITS, 8: width of the signed filter-output sample.
- WINDOW, 511: symbols per energy-measurement window.
- ACC_NBITS, 16: width of each unsigned per-phase energy accumulator.

Ports:
- clk, input, 1: system clock. One clock domain.
- rst, input, 1: synchronous, active-low reset.
- enable, input, 1: sample-valid qualifier. Counters and accumulators advance only when it is high.
- filt_in, input, FILT_NBITS: signed two's-complement RX filter output.
- phase_sel, output, clog2(OS_RATE): selected sampling phase.
- locked, output, 1: high once the first window has been evaluated.
- bit_out, output, 1: hard decision.
- bit_valid, output, 1: one-cycle strobe qualifying bit_out.

## Operation
- States:
  - IDLE: the state after reset.
  - ACQ: the first window.
  - TRACK: locked operation.
- Transitions:
  - IDLE → ACQ on the first cycle with enable=1. That sample is phase 0 of symbol 0.
  - ACQ → TRACK at the first evaluation (EVAL).
  - TRACK is held until reset. enable=0 pauses, never exits.
- Phase counter cnt runs 0..OS_RATE-1. It increments on every enable cycle and wraps to 0 after OS_RATE-1.
- Symbol counter runs 0..WINDOW-1. It increments when cnt wraps and wraps to 0 after WINDOW-1.
- Energy accumulation on each enable cycle in ACQ/TRACK:
  - acc[cnt] += |filt_in|.
  - |filt_in| is an FILT_NBITS-bit unsigned magnitude, so |−2^(FILT_NBITS-1)| = 2^(FILT_NBITS-1).
  - Accumulation saturates at 2^ACC_NBITS−1 and never wraps.
- Window end: an enable cycle with symbol counter = WINDOW-1 and cnt = OS_RATE-1. It sets a pending-EVAL flag.
- EVAL happens on the clock cycle immediately after window end, regardless of enable. On that cycle:
  - phase_sel takes argmax(acc[0..OS_RATE-1]) using the registered values, which include every sample of the window. Ties go to the lowest phase index.
  - locked is set to 1.
  - All accumulators clear. If enable=1 on the EVAL cycle, that sample instead loads acc[cnt] with |filt_in|, and all other accumulators clear.
- Decision, in TRACK only, on an enable cycle with cnt = phase_sel:
  - bit_out takes 1 if filt_in ≥ 0, otherwise 0.
  - bit_valid is 1 for the next cycle only.
- No decisions are made in IDLE or ACQ. bit_valid stays 0.

## Timing
- All outputs are registered.
- Reset values:
  - phase_sel=0, locked=0, bit_out=0, bit_valid=0.
  - All accumulators and counters = 0.
  - State = IDLE.
- Decision latency: a sample at the selected phase on edge N produces bit_valid/bit_out after edge N+1. There is 1 cycle of latency.
- bit_out holds its last value while bit_valid=0.
- Lock latency: locked and the new phase_sel are visible after the EVAL edge, which is WINDOW·OS_RATE enable cycles plus 1 cycle after ACQ entry (plus any enable gaps).
- A decision made on the EVAL cycle itself uses the old phase_sel. The new phase_sel applies from the next cycle.
- An enable=0 gap freezes cnt, the symbol counter and the accumulators. The result is identical to the same stream without gaps.
- Reset asserted mid-operation (rst=0 at an edge) forces every reset value at that edge, including a pending EVAL, which is dropped.
- A phase_sel change can skip or repeat one symbol decision at the changeover. This is accepted and is not an error.

## Test plan
1. Reset and idle: hold rst=0 for 3 cycles, then rst=1 with enable=0 for 20 cycles. Required: all outputs 0 and bit_valid never asserted.
2. Acquisition (OS_RATE=4, WINDOW=4): filt_in=+100 at phase 2 and 0 elsewhere, enable=1 continuously. Required: locked=1 and phase_sel=2 after edge 17. Thereafter bit_valid pulses every 4 cycles with bit_out=1, one cycle after each phase-2 sample.
3. Tie and sign: filt_in=−50 on all phases. Required: phase_sel=0 and locked=1. Every decision has bit_out=0. With filt_in=0, every decision has bit_out=1.
4. Saturation (ACC_NBITS=9, WINDOW=4): phase 1 = −128 (sum 512), phase 3 = +127 (sum 508). Required: acc[1] saturates at 511 and phase_sel=1.
5. Enable gaps: repeat scenario 2 with enable=0 for 10 cycles inserted mid-window and on the window-end+1 cycle. Required: phase_sel, decisions and bit sequence identical to scenario 2, shifted only by the gaps. EVAL still occurs on the cycle after window end.
6. Reset mid-TRACK: after lock, pull rst=0 for 1 cycle. Required: all outputs 0 after that edge, and a fresh full window is needed before locked=1 again.
